soc_led_counter: RTL and testbench

Parametrised multi-channel LED activity counter for the PP3 SoC clock test designs. It is the successor of the fixed two-counter LED blinker. It provides CHANNELS independent counters in one clock domain, each with:
- a per-channel prescaler,
- a synchronous clear,
- a selectable counter tap driven to LEDs,
- an optional PWM brightness mode.

It sits between the global clock buffers and the board LED pins. Clear inputs come from the fabric reset outputs of the SoC macro.

---
 rtl/soc_led_pkg.sv | 16 +
 rtl/soc_led_channel.sv | 79 +++++++
 rtl/soc_led_counter.sv | 48 ++++
 tb/tb_soc_led_counter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/soc_led_pkg.sv
// Shared constants and elaboration-time parameter checks for the multi-channel LED counter.
package soc_led_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_PWM    = 1'b1;

    function automatic bit params_ok(input int unsigned channels,
                                     input int unsigned cnt_w,
                                     input int unsigned tap_lsb,
                                     input int unsigned led_per_ch,
                                     input int unsigned pwm_w);
        return (channels >= 1) && (channels <= 8) && (led_per_ch >= 1) &&
               (tap_lsb + led_per_ch <= cnt_w) && (pwm_w >= 1) && (pwm_w <= tap_lsb);
    endfunction

endpackage

// File: rtl/soc_led_channel.sv
// One LED counter channel: prescaler, counter, wrap pulse and tap/PWM output.
// PWM gating is built only when SOC_LED_PWM_EN is defined.
module soc_led_channel
    import soc_led_pkg::*;
#(
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned TAP_LSB    = 20,
    parameter int unsigned LED_PER_CH = 2,
    parameter int unsigned DIV_W      = 8,
    parameter int unsigned PWM_W      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [DIV_W-1:0]      div_i,
    input  logic                  mode_i,
    input  logic [PWM_W-1:0]      duty_i,
    output logic [LED_PER_CH-1:0] led_o,
    output logic                  wrap_o
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             tick;

    // Equality compare: a prescaler above a lowered div_i rolls through 2^DIV_W.
    assign tick = en_i && (div_q == div_i);

    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr_i) begin
            div_d = '0;
            cnt_d = '0;
        end else if (tick) begin
            div_d  = '0;
            cnt_d  = cnt_q + CNT_W'(1);
            wrap_d = &cnt_q;
        end else if (en_i) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_q  <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign wrap_o = wrap_q;

`ifdef SOC_LED_PWM_EN
    logic pwm_on;

    assign pwm_on = cnt_q[PWM_W-1:0] < duty_i;

    always_comb begin
        led_o = cnt_q[TAP_LSB +: LED_PER_CH];
        if (mode_i == MODE_PWM) begin
            led_o = cnt_q[TAP_LSB +: LED_PER_CH] & {LED_PER_CH{pwm_on}};
        end
    end
`else
    logic unused_pwm;

    assign unused_pwm = ^{mode_i, duty_i};
    assign led_o      = cnt_q[TAP_LSB +: LED_PER_CH];
`endif

endmodule

// File: rtl/soc_led_counter.sv
// Multi-channel LED activity counter; replicates soc_led_channel over flat buses.
// Optional PWM brightness mode enabled by defining SOC_LED_PWM_EN.
module soc_led_counter
    import soc_led_pkg::*;
#(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned TAP_LSB    = 20,
    parameter int unsigned LED_PER_CH = 2,
    parameter int unsigned DIV_W      = 8,
    parameter int unsigned PWM_W      = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNELS-1:0]            ch_clr,
    input  logic [CHANNELS-1:0]            ch_en,
    input  logic [CHANNELS*DIV_W-1:0]      ch_div,
    input  logic [CHANNELS-1:0]            ch_mode,
    input  logic [CHANNELS*PWM_W-1:0]      pwm_duty,
    output logic [CHANNELS*LED_PER_CH-1:0] led,
    output logic [CHANNELS-1:0]            wrap
);

    if (!params_ok(CHANNELS, CNT_W, TAP_LSB, LED_PER_CH, PWM_W)) begin : g_param_err
        $error("soc_led_counter: invalid CHANNELS/CNT_W/TAP_LSB/LED_PER_CH/PWM_W");
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        soc_led_channel #(
            .CNT_W      (CNT_W),
            .TAP_LSB    (TAP_LSB),
            .LED_PER_CH (LED_PER_CH),
            .DIV_W      (DIV_W),
            .PWM_W      (PWM_W)
        ) u_channel (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .clr_i  (ch_clr[c]),
            .en_i   (ch_en[c]),
            .div_i  (ch_div[c*DIV_W +: DIV_W]),
            .mode_i (ch_mode[c]),
            .duty_i (pwm_duty[c*PWM_W +: PWM_W]),
            .led_o  (led[c*LED_PER_CH +: LED_PER_CH]),
            .wrap_o (wrap[c])
        );
    end

endmodule

// File: tb/tb_soc_led_counter.sv
// Self-checking bench for soc_led_counter: constant-expectation vector table, directed
// corner sequences, and randomized stimulus against an arithmetic reference model.
module tb_soc_led_counter;

    localparam int CH    = 2;
    localparam int CNT_W = 10;
    localparam int TAP   = 8;
    localparam int LPC   = 2;
    localparam int DIV_W = 4;
    localparam int PWM_W = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [CH-1:0]        ch_clr, ch_en, ch_mode;
    logic [CH*DIV_W-1:0]  ch_div;
    logic [CH*PWM_W-1:0]  pwm_duty;
    logic [CH*LPC-1:0]    led;
    logic [CH-1:0]        wrap;

    int checks = 0;
    int errors = 0;

    // Reference model: prescaler phase, counter value and pending wrap per channel.
    int m_pre [CH];
    int m_cnt [CH];
    int m_wrap[CH];

    soc_led_counter #(
        .CHANNELS   (CH),
        .CNT_W      (CNT_W),
        .TAP_LSB    (TAP),
        .LED_PER_CH (LPC),
        .DIV_W      (DIV_W),
        .PWM_W      (PWM_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_clr   (ch_clr),
        .ch_en    (ch_en),
        .ch_div   (ch_div),
        .ch_mode  (ch_mode),
        .pwm_duty (pwm_duty),
        .led      (led),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CH*LPC-1:0] model_led();
        logic [CH*LPC-1:0] v;
        int tap, duty;
        v = '0;
        for (int c = 0; c < CH; c++) begin
            tap  = (m_cnt[c] / (2 ** TAP)) % (2 ** LPC);
            duty = int'(pwm_duty[c*PWM_W +: PWM_W]);
`ifdef SOC_LED_PWM_EN
            if (ch_mode[c] && ((m_cnt[c] % (2 ** PWM_W)) >= duty)) tap = 0;
`else
            if (duty < 0) tap = 0;
`endif
            v[c*LPC +: LPC] = tap[LPC-1:0];
        end
        return v;
    endfunction

    function automatic logic [CH-1:0] model_wrap();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = (m_wrap[c] != 0);
        return v;
    endfunction

    task automatic model_edge();
        int div;
        for (int c = 0; c < CH; c++) begin
            div = int'(ch_div[c*DIV_W +: DIV_W]);
            m_wrap[c] = 0;
            if (!rst_n || ch_clr[c]) begin
                m_pre[c] = 0;
                m_cnt[c] = 0;
            end else if (ch_en[c]) begin
                if (m_pre[c] == div) begin
                    m_pre[c]  = 0;
                    m_wrap[c] = (m_cnt[c] == 2 ** CNT_W - 1) ? 1 : 0;
                    m_cnt[c]  = (m_cnt[c] + 1) % (2 ** CNT_W);
                end else begin
                    m_pre[c] = (m_pre[c] + 1) % (2 ** DIV_W);
                end
            end
        end
    endtask

    // One clock edge with the current inputs, then compare against the model.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("led_model", 32'(led), 32'(model_led()));
        check("wrap_model", 32'(wrap), 32'(model_wrap()));
    endtask

    typedef struct {
        string      name;
        logic       rst_n;
        logic [1:0] clr, en, mode;
        logic [3:0] div0, div1;
        logic [7:0] duty;
        int         n;
        logic [3:0] exp_led;
        logic [1:0] exp_wrap;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int on_cnt;
        logic [3:0] pwm_off_led;
`ifdef SOC_LED_PWM_EN
        pwm_off_led = 4'b0000;
`else
        pwm_off_led = 4'b0100;
`endif
        // ch0 counts every cycle, ch1 every 4 cycles; TAP=8 so led steps every 256 counts.
        tbl[0] = '{"reset",       1'b0, 2'b00, 2'b11, 2'b00, 4'd0, 4'd3, 8'h00,   2, 4'b0000, 2'b00};
        tbl[1] = '{"tap_256",     1'b1, 2'b00, 2'b11, 2'b00, 4'd0, 4'd3, 8'h00, 256, 4'b0001, 2'b00};
        tbl[2] = '{"tap_768",     1'b1, 2'b00, 2'b11, 2'b00, 4'd0, 4'd3, 8'h00, 512, 4'b0011, 2'b00};
        tbl[3] = '{"all_ones",    1'b1, 2'b00, 2'b11, 2'b00, 4'd0, 4'd3, 8'h00, 255, 4'b0011, 2'b00};
        tbl[4] = '{"wrap_pulse",  1'b1, 2'b00, 2'b11, 2'b00, 4'd0, 4'd3, 8'h00,   1, 4'b0100, 2'b01};
        tbl[5] = '{"wrap_end",    1'b1, 2'b00, 2'b11, 2'b00, 4'd0, 4'd3, 8'h00,   1, 4'b0100, 2'b00};
        tbl[6] = '{"clr_ch0",     1'b1, 2'b01, 2'b11, 2'b00, 4'd0, 4'd3, 8'h00,   1, 4'b0100, 2'b00};
        tbl[7] = '{"dis_ch0",     1'b1, 2'b00, 2'b10, 2'b00, 4'd0, 4'd3, 8'h00, 100, 4'b0100, 2'b00};
        tbl[8] = '{"pwm_duty0",   1'b1, 2'b00, 2'b10, 2'b11, 4'd0, 4'd3, 8'h00,   1, pwm_off_led, 2'b00};

        for (int c = 0; c < CH; c++) begin
            m_pre[c] = 0;
            m_cnt[c] = 0;
            m_wrap[c] = 0;
        end
        rst_n = 1'b0; ch_clr = '0; ch_en = '0; ch_div = '0; ch_mode = '0; pwm_duty = '0;

        for (int i = 0; i < 9; i++) begin
            rst_n    = tbl[i].rst_n;
            ch_clr   = tbl[i].clr;
            ch_en    = tbl[i].en;
            ch_mode  = tbl[i].mode;
            ch_div   = {tbl[i].div1, tbl[i].div0};
            pwm_duty = {tbl[i].duty, tbl[i].duty};
            for (int k = 0; k < tbl[i].n; k++) step();
            check({tbl[i].name, "_led"}, 32'(led), 32'(tbl[i].exp_led));
            check({tbl[i].name, "_wrap"}, 32'(wrap), 32'(tbl[i].exp_wrap));
        end

        // Randomized stimulus, including mid-count divider changes and rare resets.
        ch_clr = '0; ch_mode = '0;
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 1999) != 0);
            for (int c = 0; c < CH; c++) begin
                ch_clr[c] = ($urandom_range(0, 199) == 0);
                ch_en[c]  = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 63) == 0)
                    ch_div[c*DIV_W +: DIV_W] = ($urandom_range(0, 3) == 0) ?
                                               DIV_W'($urandom_range(0, 15)) : '0;
                if ($urandom_range(0, 31) == 0) begin
                    ch_mode[c]                = 1'($urandom_range(0, 1));
                    pwm_duty[c*PWM_W +: PWM_W] = PWM_W'($urandom_range(0, 255));
                end
            end
            step();
        end

        // Clear coincident with a wrapping tick must suppress the wrap pulse.
        rst_n = 1'b0; ch_clr = '0; ch_en = 2'b01; ch_div = '0; ch_mode = '0; pwm_duty = '0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 1023; k++) step();
        check("preload_led", 32'(led), 32'h3);
        ch_clr = 2'b01;
        step();
        check("clr_wrap_suppressed", 32'(wrap), 32'h0);
        check("clr_led_zero", 32'(led), 32'h0);
        ch_clr = 2'b00;
        ch_div = {4'd0, 4'd2};
        step();
        step();
        check("post_clr_wrap", 32'(wrap), 32'h0);

        // PWM: tap bit forced to 1, duty 0x40 gives 64 of 256 steps lit.
        rst_n = 1'b0; ch_div = '0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 256; k++) step();
        ch_mode = 2'b01;
        pwm_duty = {8'h00, 8'h40};
        #1;
        on_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            if (led[0]) on_cnt++;
            step();
        end
`ifdef SOC_LED_PWM_EN
        check("pwm_duty40_on", 32'(on_cnt), 32'd64);
`else
        check("pwm_duty40_on", 32'(on_cnt), 32'd256);
`endif
        pwm_duty = '0;
        #1;
        on_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            if (led[1]) on_cnt++;
            step();
        end
`ifdef SOC_LED_PWM_EN
        check("pwm_duty0_on", 32'(on_cnt), 32'd0);
`else
        check("pwm_duty0_on", 32'(on_cnt), 32'd256);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
